// File: rtl/hazard_unit.sv
// Pipeline interlock beside the ID stage: stalls on hazards forwarding cannot
// cover, flushes IF/ID on taken branches, and drains the pipeline on HALT.
module hazard_unit #(
  parameter int unsigned NB_REG_ADDR  = 5,
  parameter int unsigned NB_STALL     = 2,
  parameter int unsigned NB_DRAIN     = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_REG_ADDR-1:0] i_rs,
  input  logic [NB_REG_ADDR-1:0] i_rt,
  input  logic                   i_use_rs,
  input  logic                   i_use_rt,
  input  logic                   i_branch,
  input  logic                   i_jump_rs,
  input  logic                   i_halt,
  input  logic                   i_taken,
  input  logic [NB_REG_ADDR-1:0] i_rd_ex,
  input  logic                   i_we_ex,
  input  logic                   i_load_ex,
  input  logic [NB_REG_ADDR-1:0] i_rd_mem,
  input  logic                   i_we_mem,
  input  logic                   i_load_mem,
  output logic                   o_pc_we,
  output logic                   o_ifid_we,
  output logic                   o_ifid_flush,
  output logic                   o_idex_bubble,
  output logic                   o_halted
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t              r_state, w_next_state;
  logic [NB_STALL-1:0] r_scnt, w_scnt_next;
  logic [NB_DRAIN-1:0] r_dcnt, w_dcnt_next;

  logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic       w_m_ex, w_m_mem, w_id_cons;
  logic [1:0] w_need;
  logic       w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble, w_halted;

  // Register 0 is hardwired, so it never produces a dependency
  assign w_rs_ex  = i_use_rs & i_we_ex  & (i_rs == i_rd_ex)  & (i_rs != '0);
  assign w_rt_ex  = i_use_rt & i_we_ex  & (i_rt == i_rd_ex)  & (i_rt != '0);
  assign w_rs_mem = i_use_rs & i_we_mem & (i_rs == i_rd_mem) & (i_rs != '0);
  assign w_rt_mem = i_use_rt & i_we_mem & (i_rt == i_rd_mem) & (i_rt != '0);
  assign w_m_ex    = w_rs_ex  | w_rt_ex;
  assign w_m_mem   = w_rs_mem | w_rt_mem;
  assign w_id_cons = i_branch | i_jump_rs;

  // Required stall length: the longest of all applicable rules
  always_comb begin
    w_need = 2'd0;
    if (w_id_cons) begin
      if (w_m_ex & i_load_ex)
        w_need = 2'd2;
      else if (w_m_ex | (w_m_mem & i_load_mem))
        w_need = 2'd1;
    end else if (w_m_ex & i_load_ex) begin
      w_need = 2'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= RUN;
      r_scnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_scnt  <= w_scnt_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_scnt_next   = r_scnt;
    w_dcnt_next   = r_dcnt;
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_halted      = (r_state == HALTED);
    if (!i_reset) begin
      w_idex_bubble = 1'b1;
      w_halted      = 1'b0;
    end else if (i_valid) begin
      case (r_state)
        RUN: begin
          if (w_need != 2'd0) begin
            w_idex_bubble = 1'b1;
            if (w_need == 2'd2) begin
              w_next_state = STALL;
              w_scnt_next  = NB_STALL'(1);
            end
          end else if (i_halt) begin
            w_idex_bubble = 1'b1;
            w_next_state  = DRAIN;
            w_dcnt_next   = NB_DRAIN'(DRAIN_CYCLES - 1);
          end else begin
            w_pc_we      = 1'b1;
            w_ifid_we    = 1'b1;
            w_ifid_flush = i_taken;
          end
        end
        STALL: begin
          w_idex_bubble = 1'b1;
          if (r_scnt <= NB_STALL'(1)) begin
            w_next_state = RUN;
            w_scnt_next  = '0;
          end else begin
            w_scnt_next = r_scnt - NB_STALL'(1);
          end
        end
        DRAIN: begin
          w_idex_bubble = 1'b1;
          if (r_dcnt == '0)
            w_next_state = HALTED;
          else
            w_dcnt_next = r_dcnt - NB_DRAIN'(1);
        end
        HALTED: w_idex_bubble = 1'b1;
        default: w_next_state = RUN;
      endcase
    end
  end

  assign o_pc_we       = w_pc_we;
  assign o_ifid_we     = w_ifid_we;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_halted      = w_halted;

endmodule
